// File: rtl/key_decoder_multi.sv
// key_decoder_multi
//   Tracks the held state of N_KEYS PS/2 make codes taken from a 16-bit
//   keycode word {previous byte, last byte}. A previous byte of F0 marks a
//   break. Produces registered held state, one-cycle press/release strobes
//   and a registered any-held flag.
//   Optional per-channel auto-repeat is built when the macro
//   KEY_AUTOREPEAT_EN is defined; otherwise key_repeat is tied low.
module key_decoder_multi #(
    parameter int unsigned              N_KEYS        = 4,
    parameter logic [8*N_KEYS-1:0]      KEY_CODES     = 32'h1C1D_295A,
    parameter int unsigned              REPEAT_DELAY  = 50_000_000,
    parameter int unsigned              REPEAT_PERIOD = 10_000_000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [15:0]         keycode,
    output logic [N_KEYS-1:0]   key_held,
    output logic [N_KEYS-1:0]   key_press,
    output logic [N_KEYS-1:0]   key_release,
    output logic [N_KEYS-1:0]   key_repeat,
    output logic                any_held
);

    localparam logic [7:0] BREAK_PREFIX = 8'hF0;

    logic [N_KEYS-1:0] match;
    logic              is_break;

    logic [N_KEYS-1:0] held_d,    held_q;
    logic [N_KEYS-1:0] press_d,   press_q;
    logic [N_KEYS-1:0] release_d, release_q;
    logic              any_d,     any_q;

    // Per-channel code match and break detection on the current keycode word.
    always_comb begin
        is_break = (keycode[15:8] == BREAK_PREFIX);
        for (int unsigned i = 0; i < N_KEYS; i++) begin
            match[i] = (keycode[7:0] == KEY_CODES[8*i +: 8]);
        end
    end

    // Next held state plus the edge strobes derived from it.
    always_comb begin
        held_d    = (held_q & ~match) | (match & {N_KEYS{~is_break}});
        press_d   = held_d & ~held_q;
        release_d = ~held_d & held_q;
        any_d     = |held_d;
    end

    // Held state, strobes and any-held register together for single-cycle latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held_q    <= '0;
            press_q   <= '0;
            release_q <= '0;
            any_q     <= 1'b0;
        end else begin
            held_q    <= held_d;
            press_q   <= press_d;
            release_q <= release_d;
            any_q     <= any_d;
        end
    end

    assign key_held    = held_q;
    assign key_press   = press_q;
    assign key_release = release_q;
    assign any_held    = any_q;

`ifdef KEY_AUTOREPEAT_EN

    localparam int unsigned    CW          = $clog2(REPEAT_DELAY + 1);
    localparam logic [CW-1:0]  DELAY_LOAD  = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0]  PERIOD_LOAD = CW'(REPEAT_PERIOD - 1);

    logic [CW-1:0]     cnt_d [N_KEYS];
    logic [CW-1:0]     cnt_q [N_KEYS];
    logic [N_KEYS-1:0] repeat_d, repeat_q;

    // Repeat counters: load on press, count down while the key stays held,
    // fire and reload at zero. A break in the firing cycle clears instead,
    // so release wins over repeat.
    always_comb begin
        for (int unsigned i = 0; i < N_KEYS; i++) begin
            cnt_d[i]    = cnt_q[i];
            repeat_d[i] = 1'b0;
            if (press_d[i]) begin
                cnt_d[i] = DELAY_LOAD;
            end else if (!(held_q[i] && held_d[i])) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == '0) begin
                repeat_d[i] = 1'b1;
                cnt_d[i]    = PERIOD_LOAD;
            end else begin
                cnt_d[i] = cnt_q[i] - CW'(1);
            end
        end
    end

    // Counter and repeat strobe registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < N_KEYS; i++) begin
                cnt_q[i] <= '0;
            end
            repeat_q <= '0;
        end else begin
            for (int unsigned i = 0; i < N_KEYS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            repeat_q <= repeat_d;
        end
    end

    assign key_repeat = repeat_q;

`else

    // Repeat timing parameters have no effect in this build.
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = (REPEAT_DELAY >= REPEAT_PERIOD);

    assign key_repeat = '0;

`endif

endmodule

// File: doc/key_decoder_multi.md
# key_decoder_multi

Parametrised multi-key PS/2 scancode decoder and the successor to the single-key reset decoder in the keyboard path. It tracks the held state of `N_KEYS` configurable make codes from the 16-bit keyboard keycode word, where byte [15:8] = 8'hF0 marks a break. It emits one-cycle press and release strobes and optionally per-key auto-repeat strobes. Consumers are the game control and reset logic.

## Interface
Parameters:
- `N_KEYS`, 4: number of tracked channels; must be ≥ 1.
- `KEY_CODES`, 32'h1C1D_295A: packed make codes, 8 bits per channel. Channel i uses [8i+7:8i]. Default is ch0 = 5A (Enter), ch1 = 29 (Space), ch2 = 1D (W), ch3 = 1C (A). Width is 8·`N_KEYS`.
- `REPEAT_DELAY`, 50_000_000: cycles from `key_press` to the first `key_repeat`. Only used with `KEY_AUTOREPEAT_EN`. Must be ≥ `REPEAT_PERIOD`.
- `REPEAT_PERIOD`, 10_000_000: cycles between subsequent `key_repeat` pulses. Only used with `KEY_AUTOREPEAT_EN`. Must be ≥ 1.

Ports:
- `clk` in 1: single clock, all logic on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `keycode` in 16: keyboard word {previous byte, last byte}; a level, not a strobe.
- `key_held` out N_KEYS: current held state per channel.
- `key_press` out N_KEYS: one-cycle strobe on 0→1 of `key_held`.
- `key_release` out N_KEYS: one-cycle strobe on 1→0 of `key_held`.
- `key_repeat` out N_KEYS: one-cycle auto-repeat strobe; tied to 0 without `KEY_AUTOREPEAT_EN`.
- `any_held` out 1: OR of `key_held`, registered.

## Operation
- The keycode is decoded combinationally every cycle. Channel i matches when `keycode[7:0]` equals its `KEY_CODES` byte.
- Match with `keycode[15:8]` = 8'hF0 gives held_nxt[i] = 0 (break).
- Match with any other high byte gives held_nxt[i] = 1 (make, including keyboard typematic 5A5A).
- No match: held_nxt[i] keeps its value. Intermediate words with low byte F0 or E0 never match a valid code.
- `key_press` = held_nxt & ~key_held and `key_release` = ~held_nxt & key_held, both registered together with `key_held`.
- A make for an already held key gives no press. A break for a not-held key gives no release.
- A persistently presented make/break word is idempotent: a single event is produced, then nothing more.
- Duplicate codes in `KEY_CODES` update all matching channels identically.
- Only one keycode is presented per cycle, so at most one distinct code changes per cycle.
- Reset value of every output is 0: `key_held`, `key_press`, `key_release`, `key_repeat`, `any_held`, and all repeat counters. Asserting `rst` mid-hold clears held state with no release strobe. After reset, a stale make word still on `keycode` re-asserts held and press one cycle after `rst` deasserts.

## Timing
- Latency is 1 cycle: a keycode value stable before edge t is reflected in `key_held`, `key_press`, `key_release` and `any_held` after edge t.
- Strobes are high for exactly one cycle.
- Auto-repeat uses a per-channel down-counter of width $clog2(`REPEAT_DELAY`+1).
  - On the press edge it loads `REPEAT_DELAY`−1.
  - While held and nonzero, it decrements each cycle.
  - At 0 while held, it pulses `key_repeat` and reloads `REPEAT_PERIOD`−1.
  - Result: the first repeat is exactly `REPEAT_DELAY` cycles after `key_press`, then one every `REPEAT_PERIOD` cycles.
- Release or reset clears the counter. No `key_repeat` in the release cycle or after it.
- A repeat and a break in the same cycle resolve to release only.

## Configuration
- `KEY_AUTOREPEAT_EN` defined: per-channel repeat counters are built and `key_repeat` operates as in Timing.
- Not defined: no counters are synthesised, `key_repeat` is constant 0, and `REPEAT_*` are ignored. All other behaviour is identical.

## Test plan
- Reset: hold `rst`=1 with keycode 16'h005A → all outputs 0. Release `rst` → `key_held`[0]=1 and `key_press`=4'b0001 for one cycle, one cycle later.
- Make/break: apply 16'h005A for 5 cycles, then 16'h5AF0, then 16'hF05A → one `key_press`[0] pulse, `key_held`[0] high throughout the first 5 cycles and through 5AF0, one `key_release`[0] pulse one cycle after F05A, `any_held`=0.
- Multi-key: apply 001D, then 1D29, then F01D → `key_held` goes 0100 → 0110 → 0010, with press strobes on ch2 then ch1 and a release strobe on ch2.
- Spurious events: break F01C with ch3 idle → no release. Typematic 1C1C repeated while held → no second press. Unlisted code 0x33 → no change.
- Auto-repeat with `KEY_AUTOREPEAT_EN`, DELAY=10, PERIOD=4: hold 5A → `key_repeat`[0] 10 cycles after press, then at +14 and +18. Break at +20 → no further repeats. Without the macro → `key_repeat` stays 0.
- Reset mid-hold: `rst` pulses at cycle 7 of a hold with keycode F05A → everything 0, no release strobe, no repeat afterwards.
